shared_add_arbiter: RTL and testbench

- Shares one `coreir_add` instance between N requesters using valid/ready handshakes and round-robin arbitration.
- Registers the sum, tagged with the winning requester's index, into a one-deep output stage with its own valid/ready handshake.
- Sits between client blocks that need occasional additions and the single adder datapath, so the design does not replicate adders.

---
 rtl/shared_add_arbiter_pkg.sv | 52 +++++
 rtl/shared_add_arbiter_coreir_add.sv | 12 +
 rtl/shared_add_arbiter.sv | 103 ++++++++++
 tb/tb_shared_add_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/shared_add_arbiter_pkg.sv
// Shared defaults and the round-robin search helper used by the adder arbiter
// and by other arbiters that need the same rotate/encode/rotate-back search.
package shared_add_arbiter_pkg;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 8;
    localparam int MAX_N     = 16;
    localparam int IDX_W     = 4;

    typedef logic [IDX_W-1:0] rr_idx_t;
    typedef logic [IDX_W:0]   rr_idx_ext_t;

    typedef struct packed {
        logic    found;
        rr_idx_t idx;
    } rr_pick_t;

    // Rotate the request vector so ptr lands at bit 0, take the lowest set bit,
    // then map that position back to an absolute index modulo n.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_N-1:0] valid,
        input rr_idx_t          ptr,
        input int               n
    );
        logic [MAX_N-1:0] rot;
        rr_idx_ext_t      pos;
        rr_pick_t         res;
        rot = '0;
        res = '0;
        for (int k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                pos = {1'b0, ptr} + rr_idx_ext_t'(k);
                if (pos >= rr_idx_ext_t'(n)) begin
                    pos = pos - rr_idx_ext_t'(n);
                end
                rot[k] = valid[pos[IDX_W-1:0]];
            end
        end
        for (int k = 0; k < MAX_N; k++) begin
            if (!res.found && rot[k]) begin
                pos = {1'b0, ptr} + rr_idx_ext_t'(k);
                if (pos >= rr_idx_ext_t'(n)) begin
                    pos = pos - rr_idx_ext_t'(n);
                end
                res.found = 1'b1;
                res.idx   = pos[IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/shared_add_arbiter_coreir_add.sv
// Plain modular adder; carry-out is intentionally not exposed.
module coreir_add #(
    parameter int width = 8
) (
    input  logic [width-1:0] in0,
    input  logic [width-1:0] in1,
    output logic [width-1:0] out
);

    assign out = in0 + in1;

endmodule

// File: rtl/shared_add_arbiter.sv
// Round-robin sharing of a single adder between N requesters, with a one-deep
// registered result stage tagged by the winning requester index.
module shared_add_arbiter
    import shared_add_arbiter_pkg::*;
#(
    parameter int  N   = DEFAULT_N,
    parameter int  W   = DEFAULT_W,
    localparam int IDW = $clog2(N)
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic [IDW-1:0]   rsp_id
);

    logic             rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_data_q,  rsp_data_d;
    logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
    logic [IDW-1:0]   ptr_q,       ptr_d;

    logic [MAX_N-1:0] valid_ext;
    rr_pick_t         pick;
    logic             accept;
    logic             handshake;
    logic [W-1:0]     add_in0, add_in1, add_sum;

    always_comb begin
        valid_ext          = '0;
        valid_ext[N-1:0]   = req_valid;
        pick               = rr_pick(valid_ext, rr_idx_t'(ptr_q), N);
    end

    // Gating with the reset pin keeps req_ready low for the whole reset window,
    // not just after the first edge.
    assign accept    = !rsp_valid_q || rsp_ready;
    assign handshake = ASYNCRESETN && accept && pick.found;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign req_ready[gi] = handshake && (pick.idx == rr_idx_t'(gi));
        end
    endgenerate

    always_comb begin
        add_in0 = '0;
        add_in1 = '0;
        for (int i = 0; i < N; i++) begin
            if (pick.idx == rr_idx_t'(i)) begin
                add_in0 = req_a[i*W +: W];
                add_in1 = req_b[i*W +: W];
            end
        end
    end

    coreir_add #(
        .width (W)
    ) u_add (
        .in0 (add_in0),
        .in1 (add_in1),
        .out (add_sum)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        ptr_d       = ptr_q;
        if (handshake) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = add_sum;
            rsp_id_d    = pick.idx[IDW-1:0];
            ptr_d       = (pick.idx == rr_idx_t'(N-1)) ? '0
                        : pick.idx[IDW-1:0] + IDW'(1);
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shared_add_arbiter.sv
// Directed bench for shared_add_arbiter (N=4, W=8) plus a W=1 instance for the
// single-bit wrap case; a cycle-level reference model checks every negedge.
module tb_shared_add_arbiter;

    logic        CLK = 1'b0;
    logic        ASYNCRESETN = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;

    logic [1:0]  w1_valid = '0;
    logic [1:0]  w1_ready;
    logic [1:0]  w1_a = '0;
    logic [1:0]  w1_b = '0;
    logic        w1_rsp_valid;
    logic        w1_rsp_ready = 1'b1;
    logic [0:0]  w1_data;
    logic [0:0]  w1_id;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    shared_add_arbiter #(.N(4), .W(8)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id)
    );

    shared_add_arbiter #(.N(2), .W(1)) dut_w1 (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .req_valid   (w1_valid),
        .req_ready   (w1_ready),
        .req_a       (w1_a),
        .req_b       (w1_b),
        .rsp_valid   (w1_rsp_valid),
        .rsp_ready   (w1_rsp_ready),
        .rsp_data    (w1_data),
        .rsp_id      (w1_id)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", name, act, $time);
        end
    endtask

    // Reference model: result register contents, pointer, and the decision
    // taken for the coming edge.
    logic       m_valid;
    logic [7:0] m_data;
    logic [1:0] m_id;
    int         m_ptr;
    logic       m_hs = 1'b0;
    int         m_g = 0;
    logic [7:0] m_sum = '0;

    always @(negedge CLK) begin
        logic       acc;
        int         g;
        int         idx;
        logic [3:0] exp_ready;
        logic [7:0] av, bv;
        acc = !m_valid || rsp_ready;
        g   = -1;
        for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (req_valid[idx] && g < 0) g = idx;
        end
        exp_ready = '0;
        if (ASYNCRESETN && acc && g >= 0) exp_ready[g] = 1'b1;
        check("model_req_ready", 64'(req_ready), 64'(exp_ready));
        check("model_rsp_valid", 64'(rsp_valid), 64'(m_valid));
        check("model_rsp_data",  64'(rsp_data),  64'(m_data));
        check("model_rsp_id",    64'(rsp_id),    64'(m_id));
        m_hs = (exp_ready != 0);
        m_g  = (g < 0) ? 0 : g;
        av   = req_a[m_g*8 +: 8];
        bv   = req_b[m_g*8 +: 8];
        m_sum = av + bv;
    end

    always @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_id    <= '0;
            m_ptr   <= 0;
        end else if (m_hs) begin
            m_valid <= 1'b1;
            m_data  <= m_sum;
            m_id    <= 2'(m_g);
            m_ptr   <= (m_g + 1) % 4;
        end else if (m_valid && rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [3:0] onehot;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = 8'(8'h11 * i);
            req_b[i*8 +: 8] = 8'h01;
        end

        // Reset held with every requester valid.
        tick(); tick(); #2;
        check("reset_req_ready", 64'(req_ready), 64'h0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        check("reset_rsp_data",  64'(rsp_data),  64'h0);
        check("reset_rsp_id",    64'(rsp_id),    64'h0);
        ASYNCRESETN = 1'b1;
        #1;

        // Round-robin with all requesters valid and no backpressure.
        for (int k = 0; k < 6; k++) begin
            onehot = '0;
            onehot[k % 4] = 1'b1;
            check("rr_grant", 64'(req_ready), 64'(onehot));
            check("rr_rsp_valid", 64'(rsp_valid), (k > 0) ? 64'h1 : 64'h0);
            if (k > 0) check("rr_rsp_id", 64'(rsp_id), 64'((k - 1) % 4));
            tick(); #2;
        end

        // Single request from requester 1 (pointer now at 2).
        req_valid = 4'b0010;
        req_a[15:8] = 8'h12;
        req_b[15:8] = 8'h34;
        w1_valid = 2'b01;
        w1_a = 2'b01;
        w1_b = 2'b01;
        #1;
        check("single_req_ready", 64'(req_ready), 64'h2);
        check("w1_req_ready", 64'(w1_ready), 64'h1);
        tick(); #2;
        check("single_rsp_valid", 64'(rsp_valid), 64'h1);
        check("single_rsp_data",  64'(rsp_data),  64'h46);
        check("single_rsp_id",    64'(rsp_id),    64'h1);
        check("w1_wrap_data", 64'(w1_data), 64'h0);
        check("w1_wrap_valid", 64'(w1_rsp_valid), 64'h1);

        // 8-bit wrap from requester 3; the W=1 instance does 1+0 on requester 1.
        req_valid = 4'b1000;
        req_a[31:24] = 8'hFF;
        req_b[31:24] = 8'h01;
        w1_valid = 2'b10;
        w1_a = 2'b11;
        w1_b = 2'b01;
        #1;
        check("wrap_req_ready", 64'(req_ready), 64'h8);
        tick(); #2;
        check("wrap_rsp_data", 64'(rsp_data), 64'h00);
        check("wrap_rsp_id",   64'(rsp_id),   64'h3);
        check("w1_data_r1", 64'(w1_data), 64'h1);
        check("w1_id_r1",   64'(w1_id),   64'h1);
        w1_valid = 2'b00;

        // Backpressure while requester 2 waits.
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        req_a[23:16] = 8'h20;
        req_b[23:16] = 8'h05;
        #1;
        check("bp_req_ready", 64'(req_ready), 64'h0);
        for (int k = 0; k < 3; k++) begin
            tick(); #2;
            check("bp_hold_valid", 64'(rsp_valid), 64'h1);
            check("bp_hold_data",  64'(rsp_data),  64'h00);
            check("bp_hold_id",    64'(rsp_id),    64'h3);
            check("bp_hold_ready", 64'(req_ready), 64'h0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_ready), 64'h4);
        tick(); #2;
        check("bp_new_valid", 64'(rsp_valid), 64'h1);
        check("bp_new_data",  64'(rsp_data),  64'h25);
        check("bp_new_id",    64'(rsp_id),    64'h2);

        // Asynchronous reset between edges while a result is held.
        rsp_ready = 1'b0;
        req_valid = 4'b0000;
        #1;
        ASYNCRESETN = 1'b0;
        #1;
        check("areset_rsp_valid", 64'(rsp_valid), 64'h0);
        check("areset_rsp_data",  64'(rsp_data),  64'h0);
        tick();
        ASYNCRESETN = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #2;
        check("areset_ptr_zero", 64'(req_ready), 64'h1);

        // Mixed traffic checked by the model alone.
        for (int k = 0; k < 40; k++) begin
            tick();
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_a = $urandom;
            req_b = $urandom;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
